// File: rtl/instr_mem_responder_if.sv
// Fetch-side bus between a program-counter requester (master) and the
// instruction memory responder (slave).
interface instr_mem_responder_if #(
  parameter int data_size = 32,
  parameter int addr_size = 13
);
  logic                 mem_req;
  logic [addr_size-1:0] Address_line;
  logic                 priv;
  logic                 mem_rdy;
  logic                 mem_busy;
  logic [data_size-1:0] data_out;
  logic                 prot_fault;

  modport master (
    output mem_req, Address_line, priv,
    input  mem_rdy, mem_busy, data_out, prot_fault
  );

  modport slave (
    input  mem_req, Address_line, priv,
    output mem_rdy, mem_busy, data_out, prot_fault
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: latches a fetch address, returns the word after
// WAIT_STATES cycles with a one-cycle mem_rdy pulse. Optional macro SECURE_REGION_PROT_EN.
module instr_mem_responder #(
  parameter int                   data_size   = 32,
  parameter int                   addr_size   = 13,
  parameter int                   WAIT_STATES = 2,
  parameter logic [addr_size-1:0] PROT_BASE   = 13'h1000
) (
  input  logic                 clk_mem,
  input  logic                 reset_mem_n,
  instr_mem_responder_if.slave bus,
  input  logic                 ld_we,
  input  logic [addr_size-1:0] ld_addr,
  input  logic [data_size-1:0] ld_data,
  output logic [1:0]           dbg_state
);

  // Handshake: mem_req is a level held by the requester until mem_rdy; the
  // responder samples it only in IDLE and answers with exactly one mem_rdy cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [addr_size-1:0] addr_q, addr_d;
  logic                 priv_q, priv_d;
  logic                 rdy_q, rdy_d;
  logic [data_size-1:0] data_q, data_d;
  logic                 fault_q, fault_d;

  logic [addr_size-1:0] rd_addr;
  logic                 rd_priv;
  logic                 rd_load;
  logic                 deny;

  logic [data_size-1:0] mem [2**addr_size];

  // Loader writes land at the edge; a read sampled on the same edge sees the old word.
  always_ff @(posedge clk_mem) begin
    if (ld_we) mem[ld_addr] <= ld_data;
  end

`ifdef SECURE_REGION_PROT_EN
  assign deny = (rd_addr >= PROT_BASE) && !rd_priv;
`else
  logic unused_prot;
  assign deny        = 1'b0;
  assign unused_prot = ^{rd_priv, PROT_BASE};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    priv_d  = priv_q;
    rdy_d   = 1'b0;
    data_d  = data_q;
    fault_d = 1'b0;
    rd_addr = addr_q;
    rd_priv = priv_q;
    rd_load = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.mem_req) begin
          addr_d = bus.Address_line;
          priv_d = bus.priv;
          cnt_d  = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            // Zero wait states: the accept edge is also the response edge.
            state_d = S_RESP;
            rd_addr = bus.Address_line;
            rd_priv = bus.priv;
            rd_load = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
          rd_load = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (rd_load) begin
      rdy_d   = 1'b1;
      fault_d = deny;
      data_d  = deny ? '0 : mem[rd_addr];
    end
  end

  always_ff @(posedge clk_mem or negedge reset_mem_n) begin
    if (!reset_mem_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      priv_q  <= 1'b0;
      rdy_q   <= 1'b0;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      priv_q  <= priv_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
      fault_q <= fault_d;
    end
  end

  assign bus.mem_rdy    = rdy_q;
  assign bus.mem_busy   = (state_q != S_IDLE);
  assign bus.data_out   = data_q;
  assign bus.prot_fault = fault_q;
  assign dbg_state      = state_q;

endmodule
